fb_arbiter: RTL and testbench

Arbitrates the single-port RGB565 frame-buffer RAM between the real-time display read stream feeding `lcd_driver` and a frame writer (host/camera path). Display reads always win and have fixed latency. Writes fill idle slots through a valid/ready handshake. The block owns the display read address, wraps it per frame, and tracks the blanking interval.

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_rd_addr_gen.sv | 47 ++++
 rtl/fb_arbiter.sv | 131 +++++++++++++
 tb/tb_fb_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and state encoding for the frame-buffer arbiter slice.
// Default geometry is a 480x272 RGB565 panel.
package fb_pkg;

  localparam int H_ACTIVE_DEF = 480;
  localparam int V_ACTIVE_DEF = 272;
  localparam int FB_DEPTH     = H_ACTIVE_DEF * V_ACTIVE_DEF;
  localparam int ADDR_W_DEF   = 17;
  localparam int RGB565_W     = 16;

  // Records which RAM access is being driven this cycle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } st_e;

endpackage

// File: rtl/fb_rd_addr_gen.sv
// Display read pointer: advances per issued read, wraps at the end of the
// frame, reloads on frame_start, and flags the blanking interval.
module fb_rd_addr_gen
  import fb_pkg::*;
#(
  parameter int DEPTH  = FB_DEPTH,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_rd_issue,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_in_blank
);

  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_in_blank;
  logic              w_at_last;

  // A read coinciding with frame_start already uses the reloaded address 0.
  assign o_rd_addr  = i_frame_start ? '0 : r_rd_ptr;
  assign w_at_last  = (o_rd_addr == LP_LAST);
  assign o_in_blank = r_in_blank;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr   <= '0;
      r_in_blank <= 1'b0;
    end else begin
      if (i_rd_issue) begin
        r_rd_ptr <= w_at_last ? '0 : (o_rd_addr + ADDR_W'(1));
      end else if (i_frame_start) begin
        r_rd_ptr <= '0;
      end

      if (i_rd_issue && w_at_last) begin
        r_in_blank <= 1'b1;
      end else if (i_frame_start) begin
        r_in_blank <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads have absolute priority and a
// fixed 2-cycle latency; writer words fill idle slots. FB_ARB_BLANK_WR_EN limits writes to blanking.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = RGB565_W
) (
  input  logic              lcd_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              disp_req,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic              in_blank,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output st_e               o_dbg_st
);

  localparam int          LP_DEPTH   = H_ACTIVE * V_ACTIVE;
  localparam logic [31:0] LP_DEPTH_U = 32'(LP_DEPTH);

  st_e               r_st;
  st_e               w_st_nxt;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_disp_hold;
  logic              w_in_blank;
  logic              w_rst_active;
  logic              w_wr_ready;
  logic              w_wr_fire;
  logic              w_wr_oor;
  logic              r_req_d1;
  logic              r_req_d2;
  logic              r_wr_err;

  fb_rd_addr_gen #(
    .DEPTH  (LP_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rd_addr_gen (
    .i_clk         (lcd_clk),
    .i_rst_n       (rst_n),
    .i_frame_start (frame_start),
    .i_rd_issue    (disp_req),
    .o_rd_addr     (w_rd_addr),
    .o_in_blank    (w_in_blank)
  );

  // Writer handshake: a word transfers on any cycle where wr_valid && wr_ready;
  // wr_ready never depends on wr_valid, and an unaccepted word stays with the writer.
  assign w_rst_active = !rst_n;
`ifdef FB_ARB_BLANK_WR_EN
  assign w_wr_ready = !disp_req && !w_rst_active && w_in_blank;
`else
  assign w_wr_ready = !disp_req && !w_rst_active;
`endif
  assign w_wr_fire = wr_valid && w_wr_ready;
  assign w_wr_oor  = (32'(wr_addr) >= LP_DEPTH_U);

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) r_st <= ST_IDLE;
    else        r_st <= w_st_nxt;
  end

  always_comb begin
    w_st_nxt = ST_IDLE;
    if (disp_req)                    w_st_nxt = ST_RD;
    else if (w_wr_fire && !w_wr_oor) w_st_nxt = ST_WR;
  end

  always_comb begin
    ram_en = 1'b0;
    ram_we = 1'b0;
    case (r_st)
      ST_RD:   ram_en = 1'b1;
      ST_WR:   begin ram_en = 1'b1; ram_we = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_wr_err    <= 1'b0;
    end else begin
      r_wr_err <= w_wr_fire && w_wr_oor;
      if (w_st_nxt == ST_RD) begin
        r_ram_addr <= w_rd_addr;
      end else if (w_st_nxt == ST_WR) begin
        r_ram_addr  <= wr_addr;
        r_ram_wdata <= wr_data;
      end
    end
  end

  // Read data arrives the cycle after the enable, so the second stage lines up with ram_rdata.
  always_ff @(posedge lcd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_d1    <= 1'b0;
      r_req_d2    <= 1'b0;
      r_disp_hold <= '0;
    end else begin
      r_req_d1 <= disp_req;
      r_req_d2 <= r_req_d1;
      if (r_req_d2) r_disp_hold <= ram_rdata;
    end
  end

  assign disp_valid = r_req_d2;
  assign disp_data  = r_req_d2 ? ram_rdata : r_disp_hold;
  assign wr_ready   = w_wr_ready;
  assign wr_err     = r_wr_err;
  assign in_blank   = w_in_blank;
  assign ram_addr   = r_ram_addr;
  assign ram_wdata  = r_ram_wdata;
  assign o_dbg_st   = r_st;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter on a 16x8 frame with a behavioural synchronous RAM.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DEPTH = H * V;

  logic          lcd_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          disp_req = 1'b0;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_err;
  logic          in_blank;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  st_e           dbg_st;

  fb_arbiter #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .lcd_clk     (lcd_clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .disp_req    (disp_req),
    .disp_valid  (disp_valid),
    .disp_data   (disp_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_err      (wr_err),
    .in_blank    (in_blank),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .o_dbg_st    (dbg_st)
  );

  // clock / reset
  always #5 lcd_clk = ~lcd_clk;

  // behavioural single-port RAM
  logic [DW-1:0] ram    [2**AW];
  logic [DW-1:0] shadow [2**AW];

  always @(posedge lcd_clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  logic [1:0]    v_hist = 2'b00;
  int            exp_ptr = 0;
  logic          exp_blank = 1'b0;
  int            n_checks = 0;
  int            n_pass = 0;

  function automatic logic [DW-1:0] pat(input int i);
    return DW'(i * 37 + 16'h1357);
  endfunction

  function automatic logic exp_ready(input logic req);
`ifdef FB_ARB_BLANK_WR_EN
    return !req && exp_blank;
`else
    return !req;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // one clock: track the expected valid pipeline, then score any delivered pixel
  task automatic cycle();
    if (!rst_n) v_hist = 2'b00;
    else        v_hist = {v_hist[0], disp_req};
    @(posedge lcd_clk);
    #1;
    check("disp_valid", disp_valid, v_hist[1]);
    if (disp_valid && v_hist[1]) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check("disp_data", disp_data, exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    disp_req = 1'b0;
    frame_start = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic issue_read(input logic fs);
    int addr;
    disp_req = 1'b1;
    frame_start = fs;
    if (fs) begin
      exp_ptr = 0;
      exp_blank = 1'b0;
    end
    addr = exp_ptr;
    exp_q.push_back(shadow[addr]);
    if (exp_ptr == DEPTH - 1) begin
      exp_ptr = 0;
      exp_blank = 1'b1;
    end else begin
      exp_ptr++;
    end
    cycle();
    check("rd_addr", ram_addr, addr);
    check("rd_en", {ram_en, ram_we}, 2'b10);
    check("in_blank", in_blank, exp_blank);
    disp_req = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic write_word(input int addr, input logic [DW-1:0] data);
    wr_valid = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    #1;
    check("wr_ready_idle", wr_ready, exp_ready(1'b0));
    cycle();
    wr_valid = 1'b0;
    if (addr >= DEPTH) begin
      check("oor_ram_en", ram_en, 0);
      check("oor_wr_err", wr_err, 1);
      check("oor_st", dbg_st, ST_IDLE);
      cycle();
      check("oor_wr_err_pulse", wr_err, 0);
    end else begin
      check("wr_strobe", {ram_en, ram_we}, 2'b11);
      check("wr_addr", ram_addr, addr);
      check("wr_data", ram_wdata, data);
      check("wr_no_err", wr_err, 0);
      shadow[addr] = data;
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram[i] = pat(i);
      shadow[i] = pat(i);
    end

    // reset values
    repeat (2) @(posedge lcd_clk);
    #1;
    check("rst_ram", {ram_en, ram_we, ram_addr, ram_wdata}, '0);
    check("rst_disp", {disp_valid, disp_data}, '0);
    check("rst_flags", {wr_err, wr_ready, in_blank}, 3'b000);
    check("rst_st", dbg_st, ST_IDLE);
    rst_n = 1'b1;
    #1;
    check("wr_ready_after_rst", wr_ready, exp_ready(1'b0));

    // four back-to-back reads: addresses 0..3, valid two cycles later
    for (int i = 0; i < 4; i++) issue_read(1'b0);
    idle(2);

    // contention: display wins, writer holds its word
    wr_valid = 1'b1;
    wr_addr = AW'(100);
    wr_data = 16'h1234;
    disp_req = 1'b1;
    #1;
    check("wr_ready_contend", wr_ready, 0);
    issue_read(1'b0);
    #1;
`ifdef FB_ARB_BLANK_WR_EN
    check("wr_ready_midframe", wr_ready, 0);
    cycle();
    check("midframe_no_access", ram_en, 0);
    wr_valid = 1'b0;
`else
    check("wr_ready_released", wr_ready, 1);
    cycle();
    wr_valid = 1'b0;
    check("wr_strobe", {ram_en, ram_we}, 2'b11);
    check("wr_addr", ram_addr, 100);
    check("wr_data", ram_wdata, 16'h1234);
    shadow[100] = 16'h1234;
`endif

    // read out the rest of the frame until blanking
    for (int k = 0; k < DEPTH && !exp_blank; k++) issue_read(1'b0);
    check("blank_set", in_blank, 1);
    idle(3);
    check("sb_drained_frame", exp_q.size(), 0);

    // writes during blanking: exact out-of-range boundary and last valid address
    write_word(DEPTH, 16'hBEEF);
    write_word(DEPTH - 1, 16'h5A5A);
`ifdef FB_ARB_BLANK_WR_EN
    write_word(100, 16'h1234);
`endif

    // read while blanked wraps to 0; frame_start with a read also uses 0
    issue_read(1'b0);
    issue_read(1'b1);
    issue_read(1'b0);
    idle(3);

    // reset one cycle after a read request
    issue_read(1'b0);
    wr_valid = 1'b1;
    wr_addr = AW'(50);
    wr_data = 16'hCAFE;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    v_hist = 2'b00;
    exp_ptr = 0;
    exp_blank = 1'b0;
    check("midrst_ram", {ram_en, ram_we, ram_addr, ram_wdata}, '0);
    check("midrst_disp", {disp_valid, disp_data}, '0);
    check("midrst_flags", {wr_err, wr_ready, in_blank}, 3'b000);
    repeat (2) cycle();
    wr_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);
    check("post_rst_st", dbg_st, ST_IDLE);
    issue_read(1'b0);
    idle(3);
    check("sb_drained_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
